if_id_buffer: RTL and testbench

- Elastic pipeline stage between instruction fetch and decode in the RV64I core.
- Accepts {PC, instruction} pairs from fetch using a valid/ready handshake and holds them in a DEPTH-entry in-order queue.
- Presents the head entry to decode along with pre-split fields, a generated 64-bit immediate and an illegal-opcode flag.
- On a taken branch (flush), discards every queued entry.

---
 rtl/riscv_pkg.sv | 63 ++++++
 rtl/imm_gen.sv | 43 ++++
 rtl/if_id_buffer.sv | 119 +++++++++++
 tb/tb_if_id_buffer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV64I definitions: opcodes, the empty-slot NOP and
// immediate-format selection used by fetch/decode.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  function automatic imm_type_e imm_type_of(
    input logic [6:0] op
  );
    imm_type_e t;
    t = IMM_NONE;
    case (op)
      OP_LOAD, OP_IMM, OP_IMM32,
      OP_JALR, OP_SYSTEM:  t = IMM_I;
      OP_STORE:            t = IMM_S;
      OP_BRANCH:           t = IMM_B;
      OP_LUI, OP_AUIPC:    t = IMM_U;
      OP_JAL:              t = IMM_J;
      default:             t = IMM_NONE;
    endcase
    return t;
  endfunction

  function automatic logic op_legal(
    input logic [6:0] op
  );
    logic ok;
    ok = 1'b0;
    case (op)
      OP_LOAD, OP_IMM, OP_IMM32,
      OP_STORE, OP_BRANCH, OP_LUI,
      OP_AUIPC, OP_JAL, OP_JALR,
      OP_OP, OP_OP32, OP_FENCE,
      OP_SYSTEM:           ok = 1'b1;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV64I immediate generator with illegal-opcode flag.
// Reused by the decode stage.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  imm_type_e sel;
  logic      sgn;

  assign sel = imm_type_of(instr[6:0]);
  assign sgn = instr[31];

  always_comb begin
    imm     = '0;
    illegal = ~op_legal(instr[6:0]);
    unique case (sel)
      IMM_I: imm = {{(XLEN-12){sgn}},
                    instr[31:20]};
      IMM_S: imm = {{(XLEN-12){sgn}},
                    instr[31:25],
                    instr[11:7]};
      IMM_B: imm = {{(XLEN-13){sgn}},
                    instr[31], instr[7],
                    instr[30:25],
                    instr[11:8], 1'b0};
      IMM_U: imm = {{(XLEN-32){sgn}},
                    instr[31:12], 12'b0};
      IMM_J: imm = {{(XLEN-21){sgn}},
                    instr[31],
                    instr[19:12],
                    instr[20],
                    instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/if_id_buffer.sv
// Elastic IF/ID queue: in-order DEPTH-entry buffer with flush,
// presenting the head pre-decoded to the decode stage.
module if_id_buffer #(
  parameter int          XLEN      = 64,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  output logic            if_ready,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [6:0]      id_opcode,
  output logic [4:0]      id_rd,
  output logic [2:0]      id_funct3,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [6:0]      id_funct7,
  output logic [XLEN-1:0] id_imm,
  output logic            id_illegal
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [XLEN-1:0] pc_d    [DEPTH];
  logic [31:0]     instr_q [DEPTH];
  logic [31:0]     instr_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic push;
  logic pop;
  logic head_vld;

  // Registered-only ready: no path from id_ready.
  assign if_ready = (count_q != FULL);
  assign head_vld = (count_q != '0);
  assign id_valid = head_vld & ~flush;
  assign push     = if_valid & if_ready & ~flush;
  assign pop      = id_valid & id_ready;

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d[wr_ptr_q]    = if_pc;
        instr_d[wr_ptr_q] = if_instr;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case (1'b1)
        (push & ~pop): count_d = count_q + CW'(1);
        (pop & ~push): count_d = count_q - CW'(1);
        default:       count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= NOP_INSTR;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= pc_d[i];
        instr_q[i] <= instr_d[i];
      end
    end
  end

  assign id_instr = head_vld ? instr_q[rd_ptr_q]
                             : NOP_INSTR;
  assign id_pc    = head_vld ? pc_q[rd_ptr_q]
                             : '0;

  assign id_opcode = id_instr[6:0];
  assign id_rd     = id_instr[11:7];
  assign id_funct3 = id_instr[14:12];
  assign id_rs1    = id_instr[19:15];
  assign id_rs2    = id_instr[24:20];
  assign id_funct7 = id_instr[31:25];

  imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instr   (id_instr),
    .imm     (id_imm),
    .illegal (id_illegal)
  );

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: reset, handshake, flush,
// immediate decode and wrap-around ordering.
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        id_ready;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rd;
  logic [2:0]  id_funct3;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [6:0]  id_funct7;
  logic [63:0] id_imm;
  logic        id_illegal;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_id_buffer #(
    .XLEN (64),
    .DEPTH(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_instr  (if_instr),
    .if_ready  (if_ready),
    .id_ready  (id_ready),
    .id_valid  (id_valid),
    .id_pc     (id_pc),
    .id_instr  (id_instr),
    .id_opcode (id_opcode),
    .id_rd     (id_rd),
    .id_funct3 (id_funct3),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .id_funct7 (id_funct7),
    .id_imm    (id_imm),
    .id_illegal(id_illegal)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] t_instr [5];
  logic [63:0] t_imm   [5];
  logic        t_ill   [5];

  initial begin
    t_instr[0] = 32'hFE21BC23; t_imm[0] = -64'sd8;
    t_ill[0]   = 1'b0;
    t_instr[1] = 32'hFE000EE3; t_imm[1] = -64'sd4;
    t_ill[1]   = 1'b0;
    t_instr[2] = 32'h123452B7;
    t_imm[2]   = 64'h0000000012345000;
    t_ill[2]   = 1'b0;
    t_instr[3] = 32'h008000EF; t_imm[3] = 64'd8;
    t_ill[3]   = 1'b0;
    t_instr[4] = 32'h0000007F; t_imm[4] = 64'd0;
    t_ill[4]   = 1'b1;

    reset    = 1'b1;
    flush    = 1'b0;
    if_valid = 1'b0;
    if_pc    = '0;
    if_instr = '0;
    id_ready = 1'b0;

    // reset held for four edges
    repeat (4) tick();
    reset = 1'b0;
    #1;
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_if_ready", 64'(if_ready), 64'd1);
    chk("rst_id_instr", 64'(id_instr), 64'h13);
    chk("rst_id_imm", id_imm, 64'd0);
    chk("rst_id_pc", id_pc, 64'd0);
    chk("rst_illegal", 64'(id_illegal), 64'd0);
    chk("rst_opcode", 64'(id_opcode), 64'h13);
    chk("rst_rd", 64'(id_rd), 64'd0);

    // pass-through
    if_valid = 1'b1;
    if_pc    = 64'h0;
    if_instr = 32'hFFF00093;
    id_ready = 1'b1;
    tick();
    if_valid = 1'b0;
    #1;
    chk("pt_valid", 64'(id_valid), 64'd1);
    chk("pt_pc", id_pc, 64'h0);
    chk("pt_rd", 64'(id_rd), 64'd1);
    chk("pt_imm", id_imm, 64'hFFFFFFFFFFFFFFFF);
    chk("pt_opcode", 64'(id_opcode), 64'h13);
    tick();
    chk("pt_drained", 64'(id_valid), 64'd0);

    // backpressure
    id_ready = 1'b0;
    if_valid = 1'b1;
    if_pc    = 64'h0;
    if_instr = 32'h00100093;
    tick();
    chk("bp_ready1", 64'(if_ready), 64'd1);
    if_pc    = 64'h4;
    if_instr = 32'h00200093;
    tick();
    chk("bp_full", 64'(if_ready), 64'd0);
    if_pc    = 64'h8;
    if_instr = 32'h00300093;
    tick();
    chk("bp_still_full", 64'(if_ready), 64'd0);
    chk("bp_head0", id_pc, 64'h0);
    if_valid = 1'b0;
    id_ready = 1'b1;
    #1;
    chk("bp_pop_rdy", 64'(if_ready), 64'd0);
    chk("bp_pop_vld", 64'(id_valid), 64'd1);
    tick();
    chk("bp_head4", id_pc, 64'h4);
    chk("bp_imm4", id_imm, 64'd2);
    chk("bp_rdy_back", 64'(if_ready), 64'd1);
    tick();
    chk("bp_no_pc8", 64'(id_valid), 64'd0);

    // flush with two queued, fetch dropped
    id_ready = 1'b0;
    if_valid = 1'b1;
    if_pc    = 64'h10;
    if_instr = 32'h00100093;
    tick();
    if_pc    = 64'h14;
    tick();
    flush    = 1'b1;
    if_pc    = 64'h40;
    id_ready = 1'b1;
    #1;
    chk("fl_valid_kill", 64'(id_valid), 64'd0);
    chk("fl_ready_full", 64'(if_ready), 64'd0);
    tick();
    flush    = 1'b0;
    if_valid = 1'b0;
    #1;
    chk("fl_empty", 64'(id_valid), 64'd0);
    chk("fl_ready", 64'(if_ready), 64'd1);
    chk("fl_pc", id_pc, 64'h0);

    // flush with room: presented fetch still dropped
    id_ready = 1'b0;
    if_valid = 1'b1;
    if_pc    = 64'h18;
    tick();
    flush = 1'b1;
    if_pc = 64'h44;
    #1;
    chk("fl2_ready", 64'(if_ready), 64'd1);
    tick();
    flush    = 1'b0;
    if_valid = 1'b0;
    #1;
    chk("fl2_empty", 64'(id_valid), 64'd0);
    tick();
    chk("fl2_no44", 64'(id_valid), 64'd0);

    // immediate decode, one entry in flight
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if_valid = 1'b1;
      if_pc    = 64'(32'h100 + 4 * i);
      if_instr = t_instr[i];
      tick();
      chk($sformatf("imm%0d_pc", i), id_pc,
          64'(32'h100 + 4 * i));
      chk($sformatf("imm%0d_val", i), id_imm,
          t_imm[i]);
      chk($sformatf("imm%0d_ill", i),
          64'(id_illegal), 64'(t_ill[i]));
    end
    if_instr = 32'h002081B3;
    if_pc    = 64'h200;
    tick();
    chk("r_imm", id_imm, 64'd0);
    chk("r_ill", 64'(id_illegal), 64'd0);
    chk("r_rd", 64'(id_rd), 64'd3);
    chk("r_rs1", 64'(id_rs1), 64'd1);
    chk("r_rs2", 64'(id_rs2), 64'd2);
    chk("r_f3", 64'(id_funct3), 64'd0);
    chk("r_f7", 64'(id_funct7), 64'd0);
    if_valid = 1'b0;
    tick();
    chk("dec_drained", 64'(id_valid), 64'd0);

    // concurrent push/pop at count=1
    id_ready = 1'b0;
    if_valid = 1'b1;
    if_pc    = 64'h0;
    if_instr = 32'h00000013;
    tick();
    id_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if_pc    = 64'(4 * (i + 1));
      if_instr = 32'h00000013 | (32'(i) << 20);
      #1;
      chk($sformatf("cc%0d_pc", i), id_pc,
          64'(4 * i));
      chk($sformatf("cc%0d_rdy", i),
          64'(if_ready), 64'd1);
      tick();
    end
    chk("cc_end_pc", id_pc, 64'h20);
    chk("cc_end_imm", id_imm, 64'd7);

    // reset mid-stream with two queued
    id_ready = 1'b0;
    if_pc    = 64'h24;
    tick();
    if_valid = 1'b0;
    #1;
    chk("mr_full", 64'(if_ready), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mr_valid", 64'(id_valid), 64'd0);
    chk("mr_ready", 64'(if_ready), 64'd1);
    chk("mr_instr", 64'(id_instr), 64'h13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
